reservation_station_array: RTL and testbench
============================================

# reservation_station_array

Multi-entry, parametrised reservation station for the out-of-order core. It sits between decode/rename and one functional unit. It buffers up to ENTRIES decoded operations, captures operand values from FWD_PORTS forwarding/commit buses, and issues the oldest operation whose operands are both resolved using a valid/ready handshake. It replaces the single-entry station: it adds depth, a configurable number of forwarding buses, age-ordered selection and flush.

## Interface
Parameters:
- ENTRIES, 4, number of station slots (≥2)
- XLEN, 64, operand data width
- CMD_W, 10, command field width
- ROBsize, 16, ROB entries; TAG_W = $clog2(ROBsize+1); tag 0 means "no dependency"
- FWD_PORTS, 3, forwarding buses; index 0 has highest priority

Ports (clock and reset first):
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all entries (mispredict recovery)
- decodeWriteEn_i  in  1  allocate request
- decodeCommands_i  in  CMD_W  command
- decodeROBTag_i  in  TAG_W  destination ROB tag
- decodeROBTag1_i / decodeROBTag2_i  in  TAG_W  source producer tags
- decodeROBval1_i / decodeROBval2_i  in  XLEN+1  bit XLEN = value valid; [XLEN-1:0] = value
- fwdValid_i  in  FWD_PORTS  bus valid per port
- fwdTag_i  in  FWD_PORTS*TAG_W  packed tags, port p at [p*TAG_W +: TAG_W]
- fwdVal_i  in  FWD_PORTS*XLEN  packed values
- issueReady_i  in  1  functional unit accepts (not stalled)
- issueValid_o  out  1  a ready entry is presented
- issueVal1_o / issueVal2_o  out  XLEN  operand values
- issueCommands_o  out  CMD_W
- issueTag_o  out  TAG_W  destination tag
- full_o  out  1  no free slot
- count_o  out  $clog2(ENTRIES+1)  occupied slots

## Operation
- Each entry holds: valid, cmd, dest tag, tag1/val1, tag2/val2, and age rank.
- Allocation: if decodeWriteEn_i & ~full_o, write into the lowest-index free slot. A source tag is stored as 0 when its decode valid bit is 1; otherwise the decode tag is stored.
- Same-cycle capture at allocation: if a stored nonzero source tag matches a valid forward bus in the same cycle, store 0 and the bus value.
- decodeWriteEn_i while full_o=1 is dropped without any state change. Upstream must not assert it.
- Wakeup: every valid entry with a nonzero source tag compares against all forward buses each cycle. If it matches a bus with fwdValid_i=1 and fwdTag_i≠0, the tag clears to 0 and the value loads. On multiple matches, the lowest port index wins.
- Forward tag 0 never matches. An operand whose tag is already 0 is never overwritten.
- Ready = valid & tag1==0 & tag2==0, evaluated on registered state.
- Select: among ready entries, the oldest (earliest allocated) is presented. Age is tracked by an age matrix or rank, not by slot index.
- Handshake: the presented entry is freed on the edge where issueValid_o & issueReady_i. Outputs are held stable while issueValid_o=1 & issueReady_i=0, unless an older entry becomes ready; in that case the older entry takes precedence next cycle.
- issue* data outputs are 0 when issueValid_o=0.
- Simultaneous issue and allocate: both occur. full_o and count_o come from registered state, so a slot freed this cycle is not reusable until the next cycle. count_o updates by +1, -1 or 0 accordingly.
- flush_i: all valid bits clear next edge; it overrides allocate, wakeup and issue in that cycle. issueValid_o is still combinationally visible that cycle, but the unit must ignore issue under flush.
- Reset (also mid-operation): all entries invalid, count_o=0, full_o=0, issueValid_o=0, issue* data=0, age state cleared.

## Timing
- Allocate with both sources valid: issueValid_o=1 in the cycle after the allocate edge (1-cycle latency).
- Forward match at edge N: the entry is ready and presentable in cycle N+1.
- Allocation capturing a forward in the same cycle behaves as if decode had presented the valid bit.
- Back-to-back issue: one entry per cycle when issueReady_i is held high.
- No combinational path from issueReady_i to any issue* output or to full_o.

## Test plan
- Reset then allocate cmd=10, dest=3, val1=65'h1_0000_0000_0000_00AA, val2=65'h1_...BB -> next cycle issueValid_o=1, Val1=AA, Val2=BB, Tag=3; issue with ready=1 -> count_o returns 0.
- Allocate dest=6, tag1=4, tag2=5 (invalid); fwd port1 tag=4 val=C, then port2 tag=5 val=D -> issueValid_o stays 0 until the cycle after the second forward, then Val1=C, Val2=D.
- Fill all 4 entries with issueReady_i=0 -> full_o=1, count_o=4; fifth decodeWriteEn_i is dropped; raise ready -> entries issue oldest-first in allocation order, one per cycle.
- Two entries wait on tag 7; ports 0 and 2 both carry tag 7 (values 1, 2) in the same cycle -> both entries capture 1; an entry allocated that same cycle with tag1=7 also captures 1.
- Younger entry ready before older; older becomes ready while younger is stalled -> older is presented first once ready; younger issues afterward.
- flush_i with 3 entries valid plus a simultaneous allocate -> count_o=0, issueValid_o=0 next cycle; repeat the test with reset_i in place of flush_i and check identical results.

Source files
------------

// File: rtl/reservation_station_array.sv
// Multi-entry reservation station: buffers decoded ops, captures operands from forwarding buses,
// and issues the oldest fully-resolved entry over a valid/ready handshake.
module reservation_station_array #(
   parameter int unsigned ENTRIES   = 4,
   parameter int unsigned XLEN      = 64,
   parameter int unsigned CMD_W     = 10,
   parameter int unsigned ROBsize   = 16,
   parameter int unsigned FWD_PORTS = 3,
   localparam int unsigned TAG_W    = $clog2(ROBsize + 1),
   localparam int unsigned CNT_W    = $clog2(ENTRIES + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       decodeWriteEn_i,
   input  logic [CMD_W-1:0]           decodeCommands_i,
   input  logic [TAG_W-1:0]           decodeROBTag_i,
   input  logic [TAG_W-1:0]           decodeROBTag1_i,
   input  logic [TAG_W-1:0]           decodeROBTag2_i,
   input  logic [XLEN:0]              decodeROBval1_i,
   input  logic [XLEN:0]              decodeROBval2_i,
   input  logic [FWD_PORTS-1:0]       fwdValid_i,
   input  logic [FWD_PORTS*TAG_W-1:0] fwdTag_i,
   input  logic [FWD_PORTS*XLEN-1:0]  fwdVal_i,
   input  logic                       issueReady_i,
   output logic                       issueValid_o,
   output logic [XLEN-1:0]            issueVal1_o,
   output logic [XLEN-1:0]            issueVal2_o,
   output logic [CMD_W-1:0]           issueCommands_o,
   output logic [TAG_W-1:0]           issueTag_o,
   output logic                       full_o,
   output logic [CNT_W-1:0]           count_o
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [CMD_W-1:0]   cmd_q   [ENTRIES];
   logic [CMD_W-1:0]   cmd_d   [ENTRIES];
   logic [TAG_W-1:0]   dest_q  [ENTRIES];
   logic [TAG_W-1:0]   dest_d  [ENTRIES];
   logic [TAG_W-1:0]   tag1_q  [ENTRIES];
   logic [TAG_W-1:0]   tag1_d  [ENTRIES];
   logic [TAG_W-1:0]   tag2_q  [ENTRIES];
   logic [TAG_W-1:0]   tag2_d  [ENTRIES];
   logic [XLEN-1:0]    val1_q  [ENTRIES];
   logic [XLEN-1:0]    val1_d  [ENTRIES];
   logic [XLEN-1:0]    val2_q  [ENTRIES];
   logic [XLEN-1:0]    val2_d  [ENTRIES];
   // older_q[j][i] set means entry j was allocated before entry i
   logic [ENTRIES-1:0] older_q [ENTRIES];
   logic [ENTRIES-1:0] older_d [ENTRIES];
   logic [CNT_W-1:0]   count_q, count_d;

   logic [ENTRIES-1:0] ready;
   logic               issue_valid;
   logic [IDX_W-1:0]   issue_idx;
   logic               alloc_ok;
   logic [IDX_W-1:0]   alloc_idx;
   logic               fire;
   logic               oldest;
   logic               found_free;

   // Resolve one operand against the forwarding buses; lowest port index wins.
   function automatic logic [TAG_W+XLEN-1:0] wake(
      input logic [TAG_W-1:0]           tag,
      input logic [XLEN-1:0]            val,
      input logic [FWD_PORTS-1:0]       fv,
      input logic [FWD_PORTS*TAG_W-1:0] ft,
      input logic [FWD_PORTS*XLEN-1:0]  fd
   );
      logic [TAG_W-1:0] t;
      logic [XLEN-1:0]  v;
      t = tag;
      v = val;
      if (tag != '0) begin
         for (int p = FWD_PORTS - 1; p >= 0; p--) begin
            if (fv[p] && (ft[p*TAG_W +: TAG_W] == tag)) begin
               t = '0;
               v = fd[p*XLEN +: XLEN];
            end
         end
      end
      return {t, v};
   endfunction

   assign full_o   = (count_q == CNT_W'(ENTRIES));
   assign count_o  = count_q;
   assign alloc_ok = decodeWriteEn_i && !full_o;
   assign fire     = issue_valid && issueReady_i;

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         ready[i] = valid_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
      end
   end

   always_comb begin
      issue_valid = 1'b0;
      issue_idx   = '0;
      oldest      = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (ready[i] && !issue_valid) begin
            oldest = 1'b1;
            for (int j = 0; j < ENTRIES; j++) begin
               if ((j != i) && ready[j] && older_q[j][i]) oldest = 1'b0;
            end
            if (oldest) begin
               issue_valid = 1'b1;
               issue_idx   = i[IDX_W-1:0];
            end
         end
      end
   end

   always_comb begin
      found_free = 1'b0;
      alloc_idx  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!valid_q[i] && !found_free) begin
            found_free = 1'b1;
            alloc_idx  = i[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      count_d = count_q;
      for (int i = 0; i < ENTRIES; i++) begin
         cmd_d[i]   = cmd_q[i];
         dest_d[i]  = dest_q[i];
         older_d[i] = older_q[i];
         {tag1_d[i], val1_d[i]} = {tag1_q[i], val1_q[i]};
         {tag2_d[i], val2_d[i]} = {tag2_q[i], val2_q[i]};
         if (valid_q[i]) begin
            {tag1_d[i], val1_d[i]} = wake(tag1_q[i], val1_q[i], fwdValid_i, fwdTag_i, fwdVal_i);
            {tag2_d[i], val2_d[i]} = wake(tag2_q[i], val2_q[i], fwdValid_i, fwdTag_i, fwdVal_i);
         end
      end

      if (fire) valid_d[issue_idx] = 1'b0;

      if (alloc_ok) begin
         valid_d[alloc_idx] = 1'b1;
         cmd_d[alloc_idx]   = decodeCommands_i;
         dest_d[alloc_idx]  = decodeROBTag_i;
         {tag1_d[alloc_idx], val1_d[alloc_idx]} =
            wake(decodeROBval1_i[XLEN] ? '0 : decodeROBTag1_i, decodeROBval1_i[XLEN-1:0],
                 fwdValid_i, fwdTag_i, fwdVal_i);
         {tag2_d[alloc_idx], val2_d[alloc_idx]} =
            wake(decodeROBval2_i[XLEN] ? '0 : decodeROBTag2_i, decodeROBval2_i[XLEN-1:0],
                 fwdValid_i, fwdTag_i, fwdVal_i);
         // New entry is younger than every existing one
         older_d[alloc_idx] = '0;
         for (int j = 0; j < ENTRIES; j++) begin
            if (j != int'(alloc_idx)) older_d[j][alloc_idx] = 1'b1;
         end
      end

      case ({alloc_ok, fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (flush_i) begin
         valid_d = '0;
         count_d = '0;
         for (int i = 0; i < ENTRIES; i++) older_d[i] = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            cmd_q[i]   <= '0;
            dest_q[i]  <= '0;
            tag1_q[i]  <= '0;
            tag2_q[i]  <= '0;
            val1_q[i]  <= '0;
            val2_q[i]  <= '0;
            older_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         for (int i = 0; i < ENTRIES; i++) begin
            cmd_q[i]   <= cmd_d[i];
            dest_q[i]  <= dest_d[i];
            tag1_q[i]  <= tag1_d[i];
            tag2_q[i]  <= tag2_d[i];
            val1_q[i]  <= val1_d[i];
            val2_q[i]  <= val2_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

   always_comb begin
      issueValid_o    = issue_valid;
      issueVal1_o     = '0;
      issueVal2_o     = '0;
      issueCommands_o = '0;
      issueTag_o      = '0;
      if (issue_valid) begin
         issueVal1_o     = val1_q[issue_idx];
         issueVal2_o     = val2_q[issue_idx];
         issueCommands_o = cmd_q[issue_idx];
         issueTag_o      = dest_q[issue_idx];
      end
   end

endmodule

// File: tb/tb_reservation_station_array.sv
// Scoreboard bench for reservation_station_array: expected issues are queued at stimulus time
// and popped by a monitor whenever a handshake completes.
module tb_reservation_station_array;

   localparam int XLEN  = 64;
   localparam int CMD_W = 10;
   localparam int TAG_W = 5;
   localparam int FP    = 3;

   typedef struct packed {
      logic [CMD_W-1:0] cmd;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset_i = 1'b1;
   logic                 flush_i = 1'b0;
   logic                 decodeWriteEn_i = 1'b0;
   logic [CMD_W-1:0]     decodeCommands_i = '0;
   logic [TAG_W-1:0]     decodeROBTag_i = '0;
   logic [TAG_W-1:0]     decodeROBTag1_i = '0;
   logic [TAG_W-1:0]     decodeROBTag2_i = '0;
   logic [XLEN:0]        decodeROBval1_i = '0;
   logic [XLEN:0]        decodeROBval2_i = '0;
   logic [FP-1:0]        fwdValid_i = '0;
   logic [FP*TAG_W-1:0]  fwdTag_i = '0;
   logic [FP*XLEN-1:0]   fwdVal_i = '0;
   logic                 issueReady_i = 1'b0;
   logic                 issueValid_o;
   logic [XLEN-1:0]      issueVal1_o;
   logic [XLEN-1:0]      issueVal2_o;
   logic [CMD_W-1:0]     issueCommands_o;
   logic [TAG_W-1:0]     issueTag_o;
   logic                 full_o;
   logic [2:0]           count_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t e;

   reservation_station_array dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .flush_i         (flush_i),
      .decodeWriteEn_i (decodeWriteEn_i),
      .decodeCommands_i(decodeCommands_i),
      .decodeROBTag_i  (decodeROBTag_i),
      .decodeROBTag1_i (decodeROBTag1_i),
      .decodeROBTag2_i (decodeROBTag2_i),
      .decodeROBval1_i (decodeROBval1_i),
      .decodeROBval2_i (decodeROBval2_i),
      .fwdValid_i      (fwdValid_i),
      .fwdTag_i        (fwdTag_i),
      .fwdVal_i        (fwdVal_i),
      .issueReady_i    (issueReady_i),
      .issueValid_o    (issueValid_o),
      .issueVal1_o     (issueVal1_o),
      .issueVal2_o     (issueVal2_o),
      .issueCommands_o (issueCommands_o),
      .issueTag_o      (issueTag_o),
      .full_o          (full_o),
      .count_o         (count_o)
   );

   always #5 clk = ~clk;

   // Every completed handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (issueValid_o && issueReady_i && !flush_i && !reset_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: got cmd=%0h tag=%0d, want no issue",
                     issueCommands_o, issueTag_o);
         end else begin
            e = exp_q.pop_front();
            if ({issueCommands_o, issueTag_o, issueVal1_o, issueVal2_o} !== e) begin
               errors++;
               $display("FAIL issue_data: got cmd=%0h tag=%0d v1=%0h v2=%0h, want cmd=%0h tag=%0d v1=%0h v2=%0h",
                        issueCommands_o, issueTag_o, issueVal1_o, issueVal2_o,
                        e.cmd, e.tag, e.v1, e.v2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      decodeWriteEn_i = 1'b0;
      fwdValid_i      = '0;
      flush_i         = 1'b0;
   endtask

   task automatic set_alloc(input logic [CMD_W-1:0] cmd, input logic [TAG_W-1:0] dest,
                            input logic [TAG_W-1:0] t1, input logic ok1, input logic [XLEN-1:0] v1,
                            input logic [TAG_W-1:0] t2, input logic ok2, input logic [XLEN-1:0] v2);
      decodeWriteEn_i  = 1'b1;
      decodeCommands_i = cmd;
      decodeROBTag_i   = dest;
      decodeROBTag1_i  = t1;
      decodeROBTag2_i  = t2;
      decodeROBval1_i  = {ok1, v1};
      decodeROBval2_i  = {ok2, v2};
   endtask

   task automatic set_fwd(input int p, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
      fwdValid_i[p]               = 1'b1;
      fwdTag_i[p*TAG_W +: TAG_W] = tag;
      fwdVal_i[p*XLEN +: XLEN]   = val;
   endtask

   task automatic push(input logic [CMD_W-1:0] cmd, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2);
      exp_q.push_back({cmd, tag, v1, v2});
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      checks++;
      if (count_o !== 3'd0) begin
         errors++; $display("FAIL reset_count: got %0d want 0", count_o);
      end
      checks++;
      if (full_o !== 1'b0) begin
         errors++; $display("FAIL reset_full: got %0b want 0", full_o);
      end
      checks++;
      if (issueValid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %0b want 0", issueValid_o);
      end
      checks++;
      if ({issueVal1_o, issueVal2_o, issueCommands_o, issueTag_o} !== '0) begin
         errors++; $display("FAIL reset_data: got v1=%0h tag=%0d want 0", issueVal1_o, issueTag_o);
      end
   endtask

   task automatic test_basic();
      issueReady_i = 1'b1;
      set_alloc(10'd10, 5'd3, 5'd0, 1'b1, 64'hAA, 5'd0, 1'b1, 64'hBB);
      push(10'd10, 5'd3, 64'hAA, 64'hBB);
      tick();
      checks++;
      if (issueValid_o !== 1'b1 || issueTag_o !== 5'd3 || issueVal1_o !== 64'hAA) begin
         errors++;
         $display("FAIL basic_present: got valid=%0b tag=%0d v1=%0h want 1/3/aa",
                  issueValid_o, issueTag_o, issueVal1_o);
      end
      tick();
      checks++;
      if (count_o !== 3'd0 || issueValid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: got count=%0d valid=%0b want 0/0", count_o, issueValid_o);
      end
   endtask

   task automatic test_wakeup();
      issueReady_i = 1'b1;
      set_alloc(10'd11, 5'd6, 5'd4, 1'b0, 64'h0, 5'd5, 1'b0, 64'h0);
      tick();
      checks++;
      if (issueValid_o !== 1'b0) begin
         errors++; $display("FAIL wake_wait0: got valid=%0b want 0", issueValid_o);
      end
      set_fwd(1, 5'd4, 64'hC);
      tick();
      checks++;
      if (issueValid_o !== 1'b0) begin
         errors++; $display("FAIL wake_wait1: got valid=%0b want 0", issueValid_o);
      end
      set_fwd(2, 5'd5, 64'hD);
      push(10'd11, 5'd6, 64'hC, 64'hD);
      tick();
      checks++;
      if (issueValid_o !== 1'b1 || issueVal1_o !== 64'hC || issueVal2_o !== 64'hD) begin
         errors++;
         $display("FAIL wake_ready: got valid=%0b v1=%0h v2=%0h want 1/c/d",
                  issueValid_o, issueVal1_o, issueVal2_o);
      end
      tick();
      checks++;
      if (count_o !== 3'd0) begin
         errors++; $display("FAIL wake_drain: got count=%0d want 0", count_o);
      end
   endtask

   task automatic test_full_order();
      issueReady_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_alloc(10'(20 + k), 5'(1 + k), 5'd0, 1'b1, 64'(k), 5'd0, 1'b1, 64'(100 + k));
         push(10'(20 + k), 5'(1 + k), 64'(k), 64'(100 + k));
         tick();
      end
      checks++;
      if (full_o !== 1'b1 || count_o !== 3'd4) begin
         errors++; $display("FAIL full_state: got full=%0b count=%0d want 1/4", full_o, count_o);
      end
      set_alloc(10'd99, 5'd9, 5'd0, 1'b1, 64'h99, 5'd0, 1'b1, 64'h99);
      tick();
      checks++;
      if (full_o !== 1'b1 || count_o !== 3'd4) begin
         errors++; $display("FAIL full_drop: got full=%0b count=%0d want 1/4", full_o, count_o);
      end
      checks++;
      if (issueCommands_o !== 10'd20) begin
         errors++; $display("FAIL full_stall_hold: got cmd=%0d want 20", issueCommands_o);
      end
      issueReady_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (count_o !== 3'(3 - k)) begin
            errors++; $display("FAIL full_drain_count: got %0d want %0d", count_o, 3 - k);
         end
      end
   endtask

   task automatic test_multi_fwd();
      issueReady_i = 1'b0;
      set_alloc(10'd30, 5'd1, 5'd7, 1'b0, 64'h0, 5'd0, 1'b1, 64'h11);
      tick();
      set_alloc(10'd31, 5'd2, 5'd7, 1'b0, 64'h0, 5'd0, 1'b1, 64'h22);
      tick();
      set_alloc(10'd32, 5'd3, 5'd7, 1'b0, 64'h0, 5'd0, 1'b1, 64'h33);
      set_fwd(0, 5'd7, 64'd1);
      set_fwd(2, 5'd7, 64'd2);
      push(10'd30, 5'd1, 64'd1, 64'h11);
      push(10'd31, 5'd2, 64'd1, 64'h22);
      push(10'd32, 5'd3, 64'd1, 64'h33);
      tick();
      checks++;
      if (count_o !== 3'd3 || issueValid_o !== 1'b1 || issueVal1_o !== 64'd1) begin
         errors++;
         $display("FAIL multi_fwd_state: got count=%0d valid=%0b v1=%0h want 3/1/1",
                  count_o, issueValid_o, issueVal1_o);
      end
      issueReady_i = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (count_o !== 3'd0) begin
         errors++; $display("FAIL multi_fwd_drain: got count=%0d want 0", count_o);
      end
   endtask

   task automatic test_age();
      issueReady_i = 1'b0;
      set_alloc(10'd40, 5'd8, 5'd9, 1'b0, 64'h0, 5'd0, 1'b1, 64'h44);
      tick();
      set_alloc(10'd41, 5'd10, 5'd0, 1'b1, 64'h66, 5'd0, 1'b1, 64'h77);
      tick();
      checks++;
      if (issueValid_o !== 1'b1 || issueTag_o !== 5'd10) begin
         errors++;
         $display("FAIL age_young_first: got valid=%0b tag=%0d want 1/10", issueValid_o, issueTag_o);
      end
      set_fwd(0, 5'd9, 64'h55);
      push(10'd40, 5'd8, 64'h55, 64'h44);
      push(10'd41, 5'd10, 64'h66, 64'h77);
      tick();
      checks++;
      if (issueTag_o !== 5'd8) begin
         errors++; $display("FAIL age_older_precedence: got tag=%0d want 8", issueTag_o);
      end
      issueReady_i = 1'b1;
      tick();
      tick();
      checks++;
      if (count_o !== 3'd0) begin
         errors++; $display("FAIL age_drain: got count=%0d want 0", count_o);
      end
   endtask

   task automatic test_clear(input bit use_reset);
      issueReady_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_alloc(10'(50 + k), 5'(1 + k), 5'd0, 1'b1, 64'(k), 5'd0, 1'b1, 64'(k));
         tick();
      end
      set_alloc(10'd60, 5'd12, 5'd0, 1'b1, 64'h1, 5'd0, 1'b1, 64'h2);
      if (use_reset) reset_i = 1'b1;
      else flush_i = 1'b1;
      tick();
      reset_i = 1'b0;
      checks++;
      if (count_o !== 3'd0 || issueValid_o !== 1'b0 || full_o !== 1'b0 || issueTag_o !== 5'd0) begin
         errors++;
         $display("FAIL clear_state(reset=%0b): got count=%0d valid=%0b full=%0b tag=%0d want 0/0/0/0",
                  use_reset, count_o, issueValid_o, full_o, issueTag_o);
      end
      issueReady_i = 1'b1;
      set_alloc(10'd61, 5'd13, 5'd0, 1'b1, 64'h5, 5'd0, 1'b1, 64'h6);
      push(10'd61, 5'd13, 64'h5, 64'h6);
      tick();
      tick();
      checks++;
      if (count_o !== 3'd0) begin
         errors++; $display("FAIL clear_recover(reset=%0b): got count=%0d want 0", use_reset, count_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_full_order();
      test_multi_fwd();
      test_age();
      test_clear(1'b0);
      test_clear(1'b1);
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
